wash_sequencer: RTL

Cycle scheduler for the washing-machine controller. It accepts a start request and a load mode, then sequences the shared water valves and drum motor through fill, agitate, drain and spin steps for the wash, rinse and spin phases. It also drives the door lock and reports a phase code and remaining seconds for the status lights and seven-segment display logic.

---
 rtl/wash_sequencer.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/wash_sequencer.sv
// wash_sequencer: schedules fill / agitate / drain / spin steps for the wash,
// rinse and spin phases of a washing machine. It drives the valves, the drum
// motor and the door lock, and reports a phase code and the seconds remaining.
module wash_sequencer #(
  parameter int TICK_DIV = 100000000,  // clk cycles per one-second tick
  parameter int W_SMALL  = 10,         // wash agitate seconds, mode 01
  parameter int W_MED    = 20,         // wash agitate seconds, mode 10
  parameter int W_LARGE  = 30,         // wash agitate seconds, mode 11
  parameter int RINSE_T  = 10,         // rinse agitate seconds
  parameter int SPIN_T   = 15,         // spin seconds
  parameter int FILL_TO  = 30,         // fill timeout seconds
  parameter int DRAIN_TO = 30          // drain timeout seconds
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       pause,
  input  logic       door_closed,
  input  logic       water_full,
  input  logic       water_empty,
  output logic [1:0] phase,
  output logic [1:0] motor,
  output logic       valve_in,
  output logic       valve_out,
  output logic       door_lock,
  output logic       busy,
  output logic [6:0] remain,
  output logic       done,
  output logic       err
);

  localparam int S_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [S_W-1:0] SUB_LAST = S_W'(TICK_DIV - 1);

  localparam logic [6:0] L_W_SMALL  = 7'(W_SMALL);
  localparam logic [6:0] L_W_MED    = 7'(W_MED);
  localparam logic [6:0] L_W_LARGE  = 7'(W_LARGE);
  localparam logic [6:0] L_RINSE_T  = 7'(RINSE_T);
  localparam logic [6:0] L_SPIN_T   = 7'(SPIN_T);
  localparam logic [6:0] FILL_LAST  = 7'(FILL_TO - 1);
  localparam logic [6:0] DRAIN_LAST = 7'(DRAIN_TO - 1);
  localparam logic [6:0] SPIN_LAST  = 7'(SPIN_T - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_AGITATE,
    S_DRAIN,
    S_SPIN,
    S_DONE,
    S_ERR
  } state_t;

  state_t         r_state, w_state_nxt;
  logic           r_rf, w_rf_nxt;           // 0 = wash pass, 1 = rinse pass
  logic [1:0]     r_mode, w_mode_nxt;       // load mode latched at start
  logic [S_W-1:0] r_sub, w_sub_nxt;         // sub-second cycle counter
  logic [6:0]     r_elapsed, w_elapsed_nxt; // elapsed seconds in this state
  logic           r_hold;                   // registered pause / door-open

  logic           w_busy;
  logic           w_adv;
  logic           w_tick;
  logic [6:0]     w_agit_len;

  assign w_busy = (r_state != S_IDLE) && (r_state != S_ERR);
  assign w_adv  = w_busy && !pause && door_closed;
  assign w_tick = w_adv && (r_sub == SUB_LAST);

  // Agitate length: rinse pass has its own time, wash pass depends on load.
  always_comb begin
    w_agit_len = L_W_SMALL;
    if (r_rf) begin
      w_agit_len = L_RINSE_T;
    end else begin
      case (r_mode)
        2'b10:   w_agit_len = L_W_MED;
        2'b11:   w_agit_len = L_W_LARGE;
        default: w_agit_len = L_W_SMALL;
      endcase
    end
  end

  // Next-state, pass flag, latched mode and second counters.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_state_nxt   = r_state;
    w_rf_nxt      = r_rf;
    w_mode_nxt    = r_mode;
    w_sub_nxt     = r_sub;
    w_elapsed_nxt = r_elapsed;

    if (w_adv) begin
      if (w_tick) begin
        w_sub_nxt     = '0;
        w_elapsed_nxt = r_elapsed + 7'd1;
      end else begin
        w_sub_nxt = r_sub + 1'b1;
      end
    end

    case (r_state)
      S_IDLE: begin
        if (start && door_closed) begin
          w_mode_nxt  = mode;
          w_rf_nxt    = 1'b0;
          w_state_nxt = (mode == 2'b00) ? S_DRAIN : S_FILL;
        end
      end
      S_FILL: begin
        // Sensor exit has priority over the timeout on the same edge.
        if (w_adv) begin
          if (water_full) begin
            w_state_nxt = S_AGITATE;
          end else if (w_tick && (r_elapsed == FILL_LAST)) begin
            w_state_nxt = S_ERR;
          end
        end
      end
      S_AGITATE: begin
        if (w_tick && (r_elapsed == w_agit_len - 7'd1)) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_adv) begin
          if (water_empty) begin
            if (!r_rf && (r_mode != 2'b00)) begin
              w_rf_nxt    = 1'b1;
              w_state_nxt = S_FILL;
            end else begin
              w_state_nxt = S_SPIN;
            end
          end else if (w_tick && (r_elapsed == DRAIN_LAST)) begin
            w_state_nxt = S_ERR;
          end
        end
      end
      S_SPIN: begin
        if (w_tick && (r_elapsed == SPIN_LAST)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      S_ERR:   w_state_nxt = S_ERR;
      default: w_state_nxt = S_IDLE;
    endcase

    // Second counters restart with every state change.
    if (w_state_nxt != r_state) begin
      w_sub_nxt     = '0;
      w_elapsed_nxt = '0;
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      r_state   <= S_IDLE;
      r_rf      <= 1'b0;
      r_mode    <= 2'b00;
      r_sub     <= '0;
      r_elapsed <= '0;
      r_hold    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rf      <= w_rf_nxt;
      r_mode    <= w_mode_nxt;
      r_sub     <= w_sub_nxt;
      r_elapsed <= w_elapsed_nxt;
      r_hold    <= pause || !door_closed;
    end
  end

  // Output decode from registered state only.
  always_comb begin
    phase     = 2'b00;
    motor     = 2'b00;
    valve_in  = 1'b0;
    valve_out = 1'b0;
    remain    = 7'd0;
    busy      = w_busy;
    door_lock = w_busy && (r_state != S_DONE);
    done      = (r_state == S_DONE);
    err       = (r_state == S_ERR);

    case (r_state)
      S_FILL: begin
        phase    = r_rf ? 2'b10 : 2'b01;
        valve_in = !r_hold;
      end
      S_AGITATE: begin
        phase  = r_rf ? 2'b10 : 2'b01;
        remain = w_agit_len - r_elapsed;
        if (!r_hold) begin
          motor = r_elapsed[1] ? 2'b10 : 2'b01;
        end
      end
      S_DRAIN: begin
        if (r_mode == 2'b00) begin
          phase = 2'b11;
        end else begin
          phase = r_rf ? 2'b10 : 2'b01;
        end
        valve_out = !r_hold;
      end
      S_SPIN: begin
        phase     = 2'b11;
        remain    = L_SPIN_T - r_elapsed;
        valve_out = !r_hold;
        if (!r_hold) begin
          motor = 2'b01;
        end
      end
      default: ;
    endcase
  end

endmodule
